fir_sample_sequencer: RTL and testbench
=======================================

Name: fir_sample_sequencer

Overview:
- Command-driven sequencer that streams a contiguous window of samples from the synchronous-read signal BRAM into the FIR datapath.
- Accepts a start command with base address, length and loop mode, and issues BRAM reads (1-cycle read latency).
- Delivers samples on a valid/ready stream with full backpressure, and flags the last sample and completion.
- Sits between the system controller and the FIR input. It replaces free-running, non-restartable sample readout.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- DEPTH, 101, BRAM depth in words.
- ADDR_WIDTH, $clog2(DEPTH) (7 at default), BRAM address width.
- LEN_WIDTH, ADDR_WIDTH+1, width of the length field.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset. Synchronous, active-low, clock i_clk.
- i_start  in  1  command strobe. Sampled only in IDLE.
- i_base  in  ADDR_WIDTH  first BRAM address of the window.
- i_len  in  LEN_WIDTH  number of samples in the window.
- i_loop  in  1  when 1, repeat the window until i_abort. Captured with i_start.
- i_abort  in  1  synchronous abort of the current command.
- o_bram_rden  out  1  BRAM read enable.
- o_bram_addr  out  ADDR_WIDTH  BRAM read address.
- i_bram_data  in  DATA_WIDTH  BRAM read data, valid 1 cycle after o_bram_rden.
- o_data  out  DATA_WIDTH  sample to the FIR.
- o_valid  out  1  o_data valid.
- i_ready  in  1  FIR accepts sample. Transfer occurs when o_valid && i_ready.
- o_last  out  1  qualifies the final sample of each pass.
- o_busy  out  1  command in progress.
- o_done  out  1  one-cycle pulse on command completion.
- o_err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, in-flight count 0.
- States:
  - IDLE: o_busy=0.
    - On i_start with i_len==0 or i_base+i_len>DEPTH: pulse o_err next cycle, stay IDLE, issue no reads.
    - On any other i_start: latch base, len, loop; go to RUN.
  - RUN: issue reads at addresses base..base+len-1, at most one per cycle, gated by credit.
    - After the last address, with loop=1: restart at base in the next issuing cycle. No bubble is required.
    - After the last address, with loop=0: go to DRAIN.
  - DRAIN: no reads. Wait until the FIFO is empty and nothing is in flight. Then pulse o_done and go to IDLE.
- Credit rule: 2-entry output FIFO. A read may issue only if fifo_count + inflight − pop < 2, where pop = o_valid && i_ready this cycle.
  - The FIFO never overflows.
  - Returning BRAM data is written unconditionally.
- Latency: i_start sampled at edge 0 gives o_bram_rden=1, addr=base, during cycle 1. Data is written to the FIFO at edge 2. o_valid=1 in cycle 3.
- Throughput: with i_ready held 1, one sample per cycle is sustained. A window of N samples ends with its last transfer in cycle N+2.
- Backpressure:
  - While o_valid && !i_ready, o_data and o_last hold stable.
  - Reads stall within 2 cycles and resume without loss or duplication.
- o_last: 1 exactly on the sample from address base+len-1, on every pass, including in loop mode.
- o_done: asserted the cycle after the last transfer in DRAIN. It is never asserted in loop mode.
- i_abort in RUN or DRAIN:
  - Next cycle: o_bram_rden=0 and FIFO flushed (o_valid=0). Data returning from a read already in flight is discarded.
  - Return to IDLE. o_done is not pulsed.
  - i_abort in IDLE has no effect.
- i_start while o_busy=1: ignored, no o_err.
- i_start and i_abort in the same cycle in IDLE: the command is accepted. i_abort is ignored because the state is IDLE.
- Address arithmetic: the sum base+len is computed at LEN_WIDTH+1 bits, so there is no overflow wrap in the range check. The address counter never wraps past DEPTH-1.
- Reset mid-operation: immediate return to the reset state. Any in-flight BRAM data is ignored.

Decomposition:
- Shared package: state encoding localparams (IDLE, RUN, DRAIN) and the FIFO depth constant (2).
- One sub-module: seq_skid_fifo, a 2-entry synchronous FIFO with flush, count and valid/ready pop. The FSM, address counter and credit logic stay in the top module.

Test Plan:
- BRAM init data[k]=k+100. Start base=5, len=4, loop=0, ready=1 -> o_valid in cycles 3..6 with data 105,106,107,108; o_last only on 108; o_done pulse in cycle 7; o_busy low in cycle 8.
- Same command, i_ready toggling 1,0,0,1,… -> the same 4 samples in order with no duplicates or loss; o_data stable while stalled; the FIFO never exceeds 2 entries (assertion).
- Start base=98, len=4 -> o_err pulse, no o_bram_rden, stays IDLE. Start with len=0 -> o_err pulse.
- Start base=0, len=3, loop=1 for 10 transfers -> data 100,101,102,100,101,102,…; o_last on every 102; no o_done; i_abort then gives o_valid=0 the next cycle and o_busy=0.
- i_rstn low for one cycle mid-RUN -> all outputs 0 the next cycle. A new start then streams correctly from its base.
- i_start held high during a busy command -> ignored, no o_err; o_done fires once for the first command only.

Source files
------------

// File: rtl/fir_sample_sequencer_pkg.sv
// Shared definitions for the FIR sample sequencer: FSM states and
// output FIFO geometry.
package fir_sample_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int FIFO_DEPTH  = 2;
   localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
   localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// BRAM read port and FIR sample stream of the sequencer, bundled so the
// sequencer (master) and its environment (slave) connect in one go.
interface fir_sample_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 7
);

   logic                  o_bram_rden;
   logic [ADDR_WIDTH-1:0] o_bram_addr;
   logic [DATA_WIDTH-1:0] i_bram_data;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  i_ready;
   logic                  o_last;

   modport master (
      output o_bram_rden, o_bram_addr, o_data, o_valid, o_last,
      input  i_bram_data, i_ready
   );

   modport slave (
      input  o_bram_rden, o_bram_addr, o_data, o_valid, o_last,
      output i_bram_data, i_ready
   );

endinterface

// File: rtl/fir_sample_sequencer_seq_skid_fifo.sv
// Small synchronous FIFO between the BRAM read return and the FIR stream.
// Output word is held stable while the consumer stalls; flush empties it
// in one cycle.
module seq_skid_fifo
   import fir_sample_sequencer_pkg::*;
#(
   parameter int WIDTH = 17
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   ready,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   valid,
   output logic [COUNT_WIDTH-1:0] count
);

   logic [WIDTH-1:0]     mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic                 pop;

   // A pop happens only when the consumer takes a word that is actually there
   always_comb begin
      pop = ready && (count != '0);
   end

   // Storage, pointers and occupancy; flush drops everything including a same-cycle push
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
      end
   end

   assign rd_data = mem[rd_ptr];
   assign valid   = (count != '0);

endmodule

// File: rtl/fir_sample_sequencer.sv
// Command-driven sequencer streaming a window of BRAM samples into the FIR.
// Reads are credit-gated so returning data always fits in the 2-entry FIFO.
module fir_sample_sequencer
   import fir_sample_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 101,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_start,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic [LEN_WIDTH-1:0]  i_len,
   input  logic                 i_loop,
   input  logic                 i_abort,
   fir_sample_sequencer_if.master bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);

   localparam logic [LEN_WIDTH:0] DEPTH_W = (LEN_WIDTH + 1)'(DEPTH);

   state_t                 state;
   state_t                 state_nxt;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic [ADDR_WIDTH-1:0]  end_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic                   loop_q;
   logic                   inflight;
   logic                   inflight_last;
   logic                   err_q;
   logic [LEN_WIDTH:0]     span;
   logic                   cmd_ok;
   logic                   accept;
   logic                   pop;
   logic                   credit;
   logic                   issue;
   logic                   at_end;
   logic                   flush;
   logic [2:0]             occupancy;
   logic [COUNT_WIDTH-1:0] fifo_count;
   logic [DATA_WIDTH:0]    fifo_out;
   logic                   fifo_valid;

   // Range check one bit wider than the address so base+len cannot wrap
   assign span   = (LEN_WIDTH + 1)'(i_base) + (LEN_WIDTH + 1)'(i_len);
   assign cmd_ok = (i_len != '0) && (span <= DEPTH_W);
   assign accept = (state == IDLE) && i_start && cmd_ok;

   assign pop       = fifo_valid && bus.i_ready;
   assign occupancy = 3'(fifo_count) + 3'(inflight);
   assign credit    = occupancy < (3'd2 + 3'(pop));
   assign issue     = (state == RUN) && credit;
   assign at_end    = (addr_q == end_q);
   assign flush     = i_abort && (state != IDLE);

   // Next-state decisions and the combinational outputs
   always_comb begin
      state_nxt       = state;
      o_busy          = (state != IDLE);
      o_done          = 1'b0;
      bus.o_bram_rden = issue;
      bus.o_bram_addr = addr_q;
      case (state)
         IDLE: begin
            if (accept) state_nxt = RUN;
         end
         RUN: begin
            if (i_abort)                         state_nxt = IDLE;
            else if (issue && at_end && !loop_q) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (i_abort) begin
               state_nxt = IDLE;
            end else if ((fifo_count == '0) && !inflight) begin
               state_nxt = IDLE;
               o_done    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register, command capture, address walk and read-return tracking
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state         <= IDLE;
         base_q        <= '0;
         end_q         <= '0;
         addr_q        <= '0;
         loop_q        <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state         <= state_nxt;
         err_q         <= (state == IDLE) && i_start && !cmd_ok;
         inflight      <= issue && !i_abort;
         inflight_last <= issue && at_end;
         if (accept) begin
            base_q <= i_base;
            end_q  <= ADDR_WIDTH'(span - 1'b1);
            addr_q <= i_base;
            loop_q <= i_loop;
         end else if (issue) begin
            addr_q <= at_end ? base_q : addr_q + 1'b1;
         end
      end
   end

   assign o_err = err_q;

   seq_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk     (i_clk),
      .rstn    (i_rstn),
      .flush   (flush),
      .push    (inflight && !flush),
      .wr_data ({inflight_last, bus.i_bram_data}),
      .ready   (bus.i_ready),
      .rd_data (fifo_out),
      .valid   (fifo_valid),
      .count   (fifo_count)
   );

   assign bus.o_valid = fifo_valid;
   assign bus.o_data  = fifo_out[DATA_WIDTH-1:0];
   assign bus.o_last  = fifo_out[DATA_WIDTH];

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Testbench for fir_sample_sequencer: directed commands against a BRAM
// holding data[k]=k+100, with a window model checking every transfer.
module tb_fir_sample_sequencer;

   logic       clk;
   logic       rstn;
   logic       start;
   logic [6:0] base;
   logic [7:0] len;
   logic       loop_mode;
   logic       abort;
   logic       busy;
   logic       done;
   logic       err;

   int passed = 0;
   int total  = 0;

   // Expected command, written by the stimulus side only
   int cmd_base   = 0;
   int cmd_len    = 1;
   bit cmd_loop   = 0;
   bit cmd_active = 0;
   int cmd_seq    = 0;

   // Model progress, written by the compare process only
   int seen_seq   = 0;
   int idx        = 0;
   int xfers      = 0;
   int done_count = 0;
   bit prev_stall = 0;
   logic [15:0] prev_data = '0;
   logic        prev_last = 1'b0;

   logic [15:0] bram [101];

   fir_sample_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(7)) bus ();

   fir_sample_sequencer #(
      .DATA_WIDTH (16),
      .DEPTH      (101)
   ) dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_start (start),
      .i_base  (base),
      .i_len   (len),
      .i_loop  (loop_mode),
      .i_abort (abort),
      .bus     (bus),
      .o_busy  (busy),
      .o_done  (done),
      .o_err   (err)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read BRAM with one cycle of latency
   initial begin
      for (int k = 0; k < 101; k++) bram[k] = 16'(k + 100);
   end
   always @(posedge clk) begin
      if (bus.o_bram_rden) bus.i_bram_data <= bram[bus.o_bram_addr];
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Presents one start command for one edge; model records it if the range rule accepts it
   task automatic apply_stimulus(input int b, input int l, input bit lp);
      start     = 1'b1;
      base      = 7'(b);
      len       = 8'(l);
      loop_mode = lp;
      if (l != 0 && b + l <= 101) begin
         cmd_base   = b;
         cmd_len    = l;
         cmd_loop   = lp;
         cmd_active = 1'b1;
         cmd_seq++;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Streams until o_done (or the budget runs out), optionally toggling ready 1,0,0,1
   task automatic stream_and_wait(input bit toggle, input int budget, output bit seen,
                                  output logic [15:0] first, output int nx);
      seen  = 1'b0;
      first = '0;
      nx    = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         bus.i_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
         @(negedge clk);
         if (bus.o_valid && bus.i_ready) begin
            if (nx == 0) first = bus.o_data;
            nx++;
         end
         if (done) seen = 1'b1;
         else sync();
      end
      check_output("done_within_budget", 32'(seen), 1);
      cmd_active = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_busy"},  32'(busy), 0);
      check_output({tag, "_done"},  32'(done), 0);
      check_output({tag, "_err"},   32'(err), 0);
      check_output({tag, "_valid"}, 32'(bus.o_valid), 0);
      check_output({tag, "_last"},  32'(bus.o_last), 0);
      check_output({tag, "_data"},  32'(bus.o_data), 0);
      check_output({tag, "_rden"},  32'(bus.o_bram_rden), 0);
   endtask

   // Every-cycle comparison of the stream against the window model
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (cmd_seq != seen_seq) begin
            seen_seq = cmd_seq;
            idx      = 0;
            xfers    = 0;
         end
         if (!cmd_active) begin
            check_output("idle_valid", 32'(bus.o_valid), 0);
            check_output("idle_rden", 32'(bus.o_bram_rden), 0);
         end
         if (bus.o_bram_rden) begin
            check_output("rd_addr_in_window",
                         32'((int'(bus.o_bram_addr) >= cmd_base) &&
                             (int'(bus.o_bram_addr) <= cmd_base + cmd_len - 1)), 1);
         end
         check_output("fifo_max_2", 32'(dut.fifo_count <= 2), 1);
         if (prev_stall) begin
            check_output("stall_valid", 32'(bus.o_valid), 1);
            check_output("stall_data", 32'(bus.o_data), 32'(prev_data));
            check_output("stall_last", 32'(bus.o_last), 32'(prev_last));
         end
         if (bus.o_valid && bus.i_ready) begin
            if (!cmd_loop && xfers >= cmd_len) begin
               total++;
               $display("[TB] FAIL extra_xfer: got transfer %0d, expected at most %0d", xfers + 1, cmd_len);
            end else begin
               check_output("xfer_data", 32'(bus.o_data), 32'(100 + cmd_base + idx));
               check_output("xfer_last", 32'(bus.o_last), 32'(idx == cmd_len - 1));
               idx = (idx + 1 == cmd_len) ? 0 : idx + 1;
            end
            xfers++;
         end
         if (done) begin
            done_count++;
            check_output("done_after_window", 32'(!cmd_loop && xfers == cmd_len), 1);
         end
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_data  = bus.o_data;
         prev_last  = bus.o_last;
      end
   end

   // Directed scenarios
   initial begin
      bit          seen;
      logic [15:0] first;
      int          nx;
      int          dc;
      int          cnt;
      bit          err_seen;
      logic [15:0] xd [32];
      logic        xl [32];

      rstn = 1'b0; start = 1'b0; base = '0; len = '0; loop_mode = 1'b0; abort = 1'b0;
      bus.i_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      sync();
      rstn = 1'b1;
      bus.i_ready = 1'b1;
      sync();

      // Basic window, ready held high, literal cycle timing
      $display("[TB] window base=5 len=4");
      apply_stimulus(5, 4, 0);
      @(negedge clk);
      check_output("c1_rden", 32'(bus.o_bram_rden), 1);
      check_output("c1_addr", 32'(bus.o_bram_addr), 5);
      check_output("c1_busy", 32'(busy), 1);
      @(negedge clk);
      check_output("c2_valid", 32'(bus.o_valid), 0);
      @(negedge clk);
      check_output("c3_valid", 32'(bus.o_valid), 1);
      check_output("c3_data", 32'(bus.o_data), 105);
      repeat (3) @(negedge clk);
      check_output("c6_data", 32'(bus.o_data), 108);
      check_output("c6_last", 32'(bus.o_last), 1);
      @(negedge clk);
      check_output("c7_done", 32'(done), 1);
      check_output("c7_valid", 32'(bus.o_valid), 0);
      cmd_active = 1'b0;
      @(negedge clk);
      check_output("c8_busy", 32'(busy), 0);
      check_output("c8_done", 32'(done), 0);
      sync();

      // Same window under backpressure
      $display("[TB] window base=5 len=4 with ready toggling");
      dc = done_count;
      apply_stimulus(5, 4, 0);
      stream_and_wait(1'b1, 60, seen, first, nx);
      check_output("bp_count", 32'(nx), 4);
      check_output("bp_first", 32'(first), 105);
      sync();
      check_output("bp_done_once", 32'(done_count - dc), 1);
      bus.i_ready = 1'b1;

      // Rejected commands
      $display("[TB] rejected commands");
      apply_stimulus(98, 4, 0);
      @(negedge clk);
      check_output("rej_err", 32'(err), 1);
      check_output("rej_rden", 32'(bus.o_bram_rden), 0);
      check_output("rej_busy", 32'(busy), 0);
      @(negedge clk);
      check_output("rej_err_pulse", 32'(err), 0);
      sync();
      apply_stimulus(3, 0, 0);
      @(negedge clk);
      check_output("len0_err", 32'(err), 1);
      check_output("len0_busy", 32'(busy), 0);
      sync();

      // Window ending exactly at the last BRAM word
      $display("[TB] boundary window base=97 len=4");
      apply_stimulus(97, 4, 0);
      stream_and_wait(1'b0, 40, seen, first, nx);
      check_output("edge_count", 32'(nx), 4);
      check_output("edge_first", 32'(first), 197);
      sync();

      // Loop mode, abort after ten transfers
      $display("[TB] loop base=0 len=3");
      dc  = done_count;
      cnt = 0;
      apply_stimulus(0, 3, 1);
      for (int i = 0; i < 60 && cnt < 10; i++) begin
         @(negedge clk);
         if (bus.o_valid && bus.i_ready) begin
            xd[cnt] = bus.o_data;
            xl[cnt] = bus.o_last;
            cnt++;
         end
         if (cnt < 10) sync();
      end
      check_output("loop_xfers", 32'(cnt), 10);
      check_output("loop_d2", 32'(xd[2]), 102);
      check_output("loop_l2", 32'(xl[2]), 1);
      check_output("loop_d3", 32'(xd[3]), 100);
      check_output("loop_l3", 32'(xl[3]), 0);
      check_output("loop_d5", 32'(xd[5]), 102);
      check_output("loop_l5", 32'(xl[5]), 1);
      sync();
      abort = 1'b1;
      sync();
      abort = 1'b0;
      cmd_active = 1'b0;
      @(negedge clk);
      check_output("abort_valid", 32'(bus.o_valid), 0);
      check_output("abort_busy", 32'(busy), 0);
      check_output("abort_rden", 32'(bus.o_bram_rden), 0);
      check_output("loop_no_done", 32'(done_count - dc), 0);
      sync();

      // Reset in the middle of a run, then a fresh command
      $display("[TB] reset mid-run");
      apply_stimulus(10, 20, 0);
      repeat (5) @(negedge clk);
      sync();
      rstn = 1'b0;
      sync();
      rstn = 1'b1;
      cmd_active = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      sync();
      apply_stimulus(20, 3, 0);
      stream_and_wait(1'b0, 40, seen, first, nx);
      check_output("restart_count", 32'(nx), 3);
      check_output("restart_first", 32'(first), 120);
      sync();

      // Start held high while busy, with an invalid command on the bus
      $display("[TB] start held while busy");
      dc       = done_count;
      err_seen = 1'b0;
      seen     = 1'b0;
      start = 1'b1; base = 7'd30; len = 8'd5; loop_mode = 1'b0;
      cmd_base = 30; cmd_len = 5; cmd_loop = 1'b0; cmd_active = 1'b1; cmd_seq++;
      sync();
      base = 7'd0;
      len  = 8'd0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (err) err_seen = 1'b1;
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
         end
      end
      check_output("held_done_seen", 32'(seen), 1);
      start = 1'b0;
      cmd_active = 1'b0;
      repeat (4) @(negedge clk);
      check_output("held_done_once", 32'(done_count - dc), 1);
      check_output("held_no_err", 32'(err_seen), 0);
      check_output("held_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
